// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage and its register file:
// default widths, opcode encoding and FSM state encoding.
package exec_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 3;
    localparam int MUL_CYC_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MUL  = 3'd3,
        S_WB   = 3'd4
    } state_t;

endpackage

// File: rtl/RegisterFile.sv
// 8-entry register file: two combinational read ports, one clocked write port.
module RegisterFile
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [DATA_W-1:0] regs_q [2**ADDR_W];

    // Write port: one entry updated per rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            regs_q[write_addr] <= write_data;
        end
    end

    assign read_data1 = regs_q[read_addr1];
    assign read_data2 = regs_q[read_addr2];

endmodule

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier. The first partial product is taken on the
// start edge, so the full product is ready (done pulses) MUL_CYC cycles
// after start, letting the caller register it on the done cycle.
module shift_add_mul #(
    parameter int DATA_W  = 8,
    parameter int MUL_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic                busy,
    output logic [2*DATA_W-1:0] product,
    output logic                done
);

    localparam logic [3:0] LAST_CNT = 4'(MUL_CYC - 1);

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state: load on start, then one multiplier bit (LSB first) per cycle.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            if (op_b[0]) begin
                acc_d = {{DATA_W{1'b0}}, op_a};
            end else begin
                acc_d = {(2*DATA_W){1'b0}};
            end
            mcand_d  = {{(DATA_W-1){1'b0}}, op_a, 1'b0};
            mplier_d = {1'b0, op_b[DATA_W-1:1]};
            cnt_d    = 4'd1;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= {(2*DATA_W){1'b0}};
            mcand_q  <= {(2*DATA_W){1'b0}};
            mplier_q <= {DATA_W{1'b0}};
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: accepts one reg-reg instruction, reads its
// operands from the register file, computes (MUL via shift-add) and writes
// the result back, updating zero/carry flags.
module alu_exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MUL_CYC = MUL_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              done,
    output logic              flag_zero,
    output logic              flag_carry
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d, carry_q, carry_d;

    logic [DATA_W:0]     sum_s;
    logic [2*DATA_W-1:0] shl_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic                alu_carry_s;
    logic                mul_start_s, mul_busy_s, mul_done_s;
    logic [2*DATA_W-1:0] mul_product_s;

    // Multiplier is kicked off on the READ edge with the live read data.
    assign mul_start_s = (state_q == S_READ) && (op_q == OP_MUL);

    shift_add_mul #(
        .DATA_W  (DATA_W),
        .MUL_CYC (MUL_CYC)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .op_a    (rf_read_data1),
        .op_b    (rf_read_data2),
        .busy    (mul_busy_s),
        .product (mul_product_s),
        .done    (mul_done_s)
    );

    // Single-cycle ALU on the captured operands.
    always_comb begin
        sum_s       = {1'b0, op_a_q} + {1'b0, op_b_q};
        shl_s       = {{DATA_W{1'b0}}, op_a_q} << op_b_q[2:0];
        alu_res_s   = op_a_q;
        alu_carry_s = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_s   = sum_s[DATA_W-1:0];
                alu_carry_s = sum_s[DATA_W];
            end
            OP_SUB: begin
                alu_res_s   = op_a_q - op_b_q;
                alu_carry_s = (op_a_q < op_b_q);
            end
            OP_AND:  alu_res_s = op_a_q & op_b_q;
            OP_OR:   alu_res_s = op_a_q | op_b_q;
            OP_XOR:  alu_res_s = op_a_q ^ op_b_q;
            OP_SHL: begin
                alu_res_s   = shl_s[DATA_W-1:0];
                alu_carry_s = |shl_s[2*DATA_W-1:DATA_W];
            end
            OP_MOV:  alu_res_s = op_a_q;
            default: alu_res_s = op_a_q;
        endcase
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                op_a_d = rf_read_data1;
                op_b_d = rf_read_data2;
                if (op_q == OP_MUL) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_res_s;
                zero_d   = (alu_res_s == {DATA_W{1'b0}});
                carry_d  = alu_carry_s;
                state_d  = S_WB;
            end
            S_MUL: begin
                if (mul_done_s) begin
                    result_d = mul_product_s[DATA_W-1:0];
                    zero_d   = (mul_product_s[DATA_W-1:0] == {DATA_W{1'b0}});
                    carry_d  = |mul_product_s[2*DATA_W-1:DATA_W];
                    state_d  = S_WB;
                end else if (!mul_busy_s) begin
                    // Multiplier idle without finishing: drop the instruction.
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            rd_q     <= {ADDR_W{1'b0}};
            rs1_q    <= {ADDR_W{1'b0}};
            rs2_q    <= {ADDR_W{1'b0}};
            op_a_q   <= {DATA_W{1'b0}};
            op_b_q   <= {DATA_W{1'b0}};
            result_q <= {DATA_W{1'b0}};
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign instr_ready   = (state_q == S_IDLE);
    assign rf_read_addr1 = rs1_q;
    assign rf_read_addr2 = rs2_q;
    assign rf_we         = (state_q == S_WB) && !rst;
    assign done          = (state_q == S_WB) && !rst;
    assign rf_write_addr = rd_q;
    assign rf_write_data = result_q;
    assign flag_zero     = zero_q;
    assign flag_carry    = carry_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute stage that drives the 8-entry × 8-bit register file (`RegisterFile`: two combinational read ports, one write port sampled on rising `clk` when `we`).
- Accepts one register-to-register instruction per valid/ready handshake.
- Reads both source operands through the file's read ports and computes the result; MUL uses an 8-cycle shift-add.
- Writes the result back through the file's write port and updates zero/carry flags.

## Interface
- `DATA_W`, 8, operand/register width
- `ADDR_W`, 3, register address width
- `MUL_CYC`, 8, multiply iterations; must equal `DATA_W`

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `instr_valid`  in  1  instruction present
- `instr_ready`  out  1  unit can accept; high exactly in IDLE
- `instr_op`  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MUL, 7 MOV
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  ADDR_W each  destination and sources
- `rf_read_addr1`, `rf_read_addr2`  out  ADDR_W each  to register-file read ports
- `rf_read_data1`, `rf_read_data2`  in  DATA_W each  combinational read data
- `rf_we`  out  1  write enable to register file
- `rf_write_addr`  out  ADDR_W  write address
- `rf_write_data`  out  DATA_W  write data
- `done`  out  1  one-cycle pulse, coincident with `rf_we`
- `flag_zero`, `flag_carry`  out  1 each  flags of last completed instruction

## Operation
- **FSM states:** IDLE, READ, EXEC, MUL, WB.
- **IDLE:**
  - `instr_ready=1`.
  - When `instr_valid` is high at the edge, latch op/rd/rs1/rs2 and go to READ.
- **READ:**
  - `rf_read_addr1/2` come from the latched rs1/rs2; they are stable from READ until the next accept.
  - Capture `rf_read_data1/2` into op_a/op_b.
  - Next state: MUL if op is 6, else EXEC.
- **EXEC:** compute and register the result and flags, then go to WB. All results are truncated to DATA_W.
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: carry = borrow (op_a < op_b unsigned).
  - AND/OR/XOR/MOV: carry = 0.
  - SHL: op_a << op_b[2:0]; carry = OR of the bits shifted out.
  - MOV: result = op_a; op_b is ignored.
  - All ops: zero = (result == 0).
- **MUL:**
  - 16-bit accumulator and 4-bit iteration counter; one multiplier bit per cycle, LSB first.
  - After `MUL_CYC` cycles, result = product[7:0], carry = (product[15:8] != 0), zero = (result == 0).
  - Go to WB.
- **WB:**
  - `rf_we=1`, `rf_write_addr`=rd, `rf_write_data`=result, `done=1`.
  - Go to IDLE.
- **Hazards:** rd equal to rs1 or rs2 is legal, since operands are read before the write.
  - Back-to-back instructions see the prior write because it lands before the next READ.
- **Reset:** synchronous; state returns to IDLE and all outputs go to 0, except `instr_ready`, which is 1 after the reset edge.
  - `rf_we` and `done` are gated by `!rst`, so no write occurs in any cycle where `rst` is high, even in WB.
  - Reset mid-operation abandons the instruction; no partial write, and flags go to 0.
- **Flags:** hold their value until the next EXEC or MUL completion.

## Timing
- Accept edge at the end of cycle N.
- **Non-MUL ops:** READ in N+1, EXEC in N+2, WB in N+3.
  - Register updated at the end of N+3.
  - `instr_ready` high again in N+4; throughput one instruction per 4 cycles.
- **MUL:** READ in N+1, MUL in N+2..N+9, WB in N+10, ready in N+11.
- Flags are visible from the WB cycle onward.
- `instr_valid` held high while `instr_ready` is low is ignored (not queued). Fields are sampled only at the accept edge.

## Structure
- **Shared package `exec_pkg`:**
  - opcode localparams `OP_ADD..OP_MOV`
  - FSM state encoding
  - `DATA_W`/`ADDR_W` defaults, shared with the register file
- **Sub-module `shift_add_mul`:**
  - ports: start, op_a, op_b, busy, product[15:0], done
  - owns the iteration counter and accumulator
  - the FSM sits in MUL until that module's done is asserted
- Everything else lives in `alu_exec_unit`.

## Test plan
The bench instantiates `RegisterFile` and `alu_exec_unit` together. It preloads r0=0x55, r1=0xAA, r7=0x03 through a bench-side mux on the write port while the unit is idle.

1. `rst` high for 2 cycles → `instr_ready=1`, `rf_we=0`, `done=0`, both flags 0.
2. ADD r2=r0+r1 → r2=0xFF in cycle N+3, zero=0, carry=0. Then ADD r3=r2+r2 → r3=0xFE, carry=1.
3. SUB r4=r0−r0 → 0x00, zero=1, carry=0. SUB r5=r0−r1 → 0xAB, carry=1.
4. MUL r6=r0×r7 → 0xFF, written in cycle N+10, carry=0. Then preload r1=0x10 and MUL r6=r1×r1 → 0x00, zero=1, carry=1.
5. `instr_valid` held high: ADD r2=r0+r1, then MOV r3=r2 presented immediately after. The second is accepted only in N+4, and r3 ends as 0xFF (RAW correct).
6. Start MUL r6=r0×r7 with r6 preset to 0x11, and assert `rst` in the 4th MUL cycle → `rf_we` never asserts, r6 stays 0x11, `instr_ready=1` after the reset edge.
